dmem_arbiter: RTL

Shares the single-port data memory between the core's load/store path and an external host port. The host port is used for preloading operands and reading back results around a run. The block sits between the control/ALU outputs and the data memory. Core accesses pass through combinationally so the single-cycle core keeps same-cycle read data. A starvation counter guarantees host progress and stalls the PC when the host takes a slot.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core load/store path vs. external host port.
// Optional host burst lock enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          host_lock,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          lock_active_q, lock_active_d;

  logic force_host;
  logic host_sel;
  logic core_sel;

  // Every grant is qualified by reset so nothing reaches memory while held.
  always_comb begin
    force_host = (wait_cnt_q == MAX_W) | lock_active_q;
    host_sel   = reset & host_req & (~core_req | force_host);
    core_sel   = reset & core_req & ~host_sel;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    unique case (1'b1)
      host_sel: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_wr_en = host_we;
        mem_rd_en = ~host_we;
      end
      core_sel: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_wr_en = core_we;
        mem_rd_en = ~core_we;
      end
      default: ;
    endcase
  end

  assign host_gnt    = host_sel;
  assign core_stall  = core_req & host_sel;
  assign core_rdata  = mem_rdata;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    host_rvalid_d = host_sel & ~host_we;
    host_rdata_d  = host_rdata_q;
    if (host_sel || !host_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_W) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    if (host_sel && !host_we) begin
      host_rdata_d = mem_rdata;
    end
`ifdef DMEM_ARB_LOCK_EN
    lock_active_d = lock_active_q;
    if (!host_req || !host_lock) begin
      lock_active_d = 1'b0;
    end else if (host_sel) begin
      lock_active_d = 1'b1;
    end
`else
    lock_active_d = host_lock & 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      lock_active_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      lock_active_q <= lock_active_d;
    end
  end

endmodule
